// File: rtl/layer5_maxpool_reader.sv
// layer5_maxpool_reader
// Reads a MAP_WIDTH x MAP_WIDTH map of LANES x LANE_WIDTH words from the
// layer-4 result memory in 2x2 windows (stride 2). For each window it takes
// a per-lane signed max and hands the pooled word to layer 5 over valid/ready.
//
// Optional build macro: LAYER5_POOL_RELU_EN
//   defined   -> negative lanes of the pooled word are clamped to 0 on output
//   undefined -> the raw signed max is output
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start                       one-cycle pulse, begins a full-map pass
//   read_row_addr/read_col_addr layer-4 memory read address
//   layer4_result_read_signal   layer-4 memory read enable
//   layer4_result_output        layer-4 memory read data
//   pool_data_out               pooled word
//   pool_row_addr/pool_col_addr pooled word position
//   pool_valid / pool_ready     output handshake
//   busy                        a pass is in progress
//   done                        one-cycle pulse after the last word is accepted
module layer5_maxpool_reader #(
    parameter int unsigned MAP_WIDTH    = 12,
    parameter int unsigned LANES        = 8,
    parameter int unsigned LANE_WIDTH   = 16,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic [15:0]                   read_row_addr,
    output logic [15:0]                   read_col_addr,
    output logic                          layer4_result_read_signal,
    input  logic [LANES*LANE_WIDTH-1:0]   layer4_result_output,
    output logic [LANES*LANE_WIDTH-1:0]   pool_data_out,
    output logic [15:0]                   pool_row_addr,
    output logic [15:0]                   pool_col_addr,
    output logic                          pool_valid,
    input  logic                          pool_ready,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned WW   = LANES * LANE_WIDTH;
    localparam int unsigned HALF = MAP_WIDTH / 2;
    localparam int unsigned CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned DW   = $clog2(READ_LATENCY + 1);
    localparam logic [CW-1:0] LAST_WIN  = CW'(HALF - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_e;

    state_e                  state_q;
    logic [CW-1:0]           wr_q, wc_q;
    logic [CW-1:0]           wr_d, wc_d;
    logic [1:0]              k_q, k_d;
    logic [DW-1:0]           drain_q;
    logic [READ_LATENCY-1:0] smp_vld_q, smp_first_q;
    logic [WW-1:0]           acc_q, acc_d;

    logic [15:0]             rd_row_q, rd_col_q;
    logic                    rd_en_q;
    logic [WW-1:0]           pool_data_q;
    logic [15:0]             pool_row_q, pool_col_q;
    logic                    pool_valid_q, busy_q, done_q;

    assign read_row_addr             = rd_row_q;
    assign read_col_addr             = rd_col_q;
    assign layer4_result_read_signal = rd_en_q;
    assign pool_data_out             = pool_data_q;
    assign pool_row_addr             = pool_row_q;
    assign pool_col_addr             = pool_col_q;
    assign pool_valid                = pool_valid_q;
    assign busy                      = busy_q;
    assign done                      = done_q;

    // Element address inside a window: 2*w + bit, i.e. {w, bit}.
    function automatic logic [15:0] win_addr(input logic [CW-1:0] w, input logic b);
        return 16'({w, b});
    endfunction

    // Output-side lane clamp; the accumulator keeps the raw max.
    function automatic logic [WW-1:0] relu(input logic [WW-1:0] w);
        logic [WW-1:0] r;
        r = w;
`ifdef LAYER5_POOL_RELU_EN
        for (int l = 0; l < int'(LANES); l++) begin
            if (w[l*LANE_WIDTH + LANE_WIDTH - 1]) begin
                r[l*LANE_WIDTH +: LANE_WIDTH] = '0;
            end
        end
`endif
        return r;
    endfunction

    // Raster advance of the window position after a handshake.
    always_comb begin
        k_d  = k_q + 2'd1;
        wr_d = wr_q;
        wc_d = wc_q + CW'(1);
        if (wc_q == LAST_WIN) begin
            wc_d = '0;
            wr_d = wr_q + CW'(1);
        end
    end

    // Accumulator next value including the element sampled this cycle.
    always_comb begin
        acc_d = acc_q;
        if (smp_vld_q[READ_LATENCY-1]) begin
            if (smp_first_q[READ_LATENCY-1]) begin
                acc_d = layer4_result_output;
            end else begin
                for (int l = 0; l < int'(LANES); l++) begin
                    if ($signed(layer4_result_output[l*LANE_WIDTH +: LANE_WIDTH]) >
                        $signed(acc_q[l*LANE_WIDTH +: LANE_WIDTH])) begin
                        acc_d[l*LANE_WIDTH +: LANE_WIDTH] =
                            layer4_result_output[l*LANE_WIDTH +: LANE_WIDTH];
                    end
                end
            end
        end
    end

    // Read-latency pipeline tagging which strobed cycles return data, and
    // which of them is the first element of a window.
    always_ff @(posedge clk) begin
        if (rst) begin
            smp_vld_q   <= '0;
            smp_first_q <= '0;
            acc_q       <= '0;
        end else begin
            smp_vld_q[0]   <= rd_en_q;
            smp_first_q[0] <= (k_q == 2'd0);
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                smp_vld_q[i]   <= smp_vld_q[i-1];
                smp_first_q[i] <= smp_first_q[i-1];
            end
            acc_q <= acc_d;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_q         <= '0;
            wc_q         <= '0;
            k_q          <= '0;
            drain_q      <= '0;
            rd_row_q     <= '0;
            rd_col_q     <= '0;
            rd_en_q      <= 1'b0;
            pool_data_q  <= '0;
            pool_row_q   <= '0;
            pool_col_q   <= '0;
            pool_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q  <= S_FETCH;
                        wr_q     <= '0;
                        wc_q     <= '0;
                        k_q      <= '0;
                        rd_row_q <= '0;
                        rd_col_q <= '0;
                        rd_en_q  <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (k_q == 2'd3) begin
                        state_q <= S_DRAIN;
                        rd_en_q <= 1'b0;
                        drain_q <= '0;
                    end else begin
                        k_q      <= k_d;
                        rd_row_q <= win_addr(wr_q, k_d[1]);
                        rd_col_q <= win_addr(wc_q, k_d[0]);
                    end
                end
                S_DRAIN: begin
                    if (drain_q == LAST_DRAIN) begin
                        state_q      <= S_OUT;
                        pool_valid_q <= 1'b1;
                        pool_data_q  <= relu(acc_d);
                        pool_row_q   <= 16'(wr_q);
                        pool_col_q   <= 16'(wc_q);
                    end else begin
                        drain_q <= drain_q + DW'(1);
                    end
                end
                S_OUT: begin
                    if (pool_ready) begin
                        pool_valid_q <= 1'b0;
                        if (wr_q == LAST_WIN && wc_q == LAST_WIN) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q  <= S_FETCH;
                            wr_q     <= wr_d;
                            wc_q     <= wc_d;
                            k_q      <= '0;
                            rd_row_q <= win_addr(wr_d, 1'b0);
                            rd_col_q <= win_addr(wc_d, 1'b0);
                            rd_en_q  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer5_maxpool_reader.sv
module tb_layer5_maxpool_reader;

    localparam int MW = 12;
    localparam int WW = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, start2, pool_ready;
    logic pool_ready2 = 1'b1;

    logic [15:0]   rrow1, rcol1, prow1, pcol1;
    logic          rsig1, pvalid1, busy1, done1;
    logic [WW-1:0] rdata1, pdata1;

    logic [15:0]   rrow2, rcol2, prow2, pcol2;
    logic          rsig2, pvalid2, busy2, done2;
    logic [WW-1:0] rdata2a, rdata2, pdata2;

    layer5_maxpool_reader u_dut (
        .clk(clk), .rst(rst), .start(start),
        .read_row_addr(rrow1), .read_col_addr(rcol1),
        .layer4_result_read_signal(rsig1), .layer4_result_output(rdata1),
        .pool_data_out(pdata1), .pool_row_addr(prow1), .pool_col_addr(pcol1),
        .pool_valid(pvalid1), .pool_ready(pool_ready),
        .busy(busy1), .done(done1)
    );

    layer5_maxpool_reader #(.READ_LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .read_row_addr(rrow2), .read_col_addr(rcol2),
        .layer4_result_read_signal(rsig2), .layer4_result_output(rdata2),
        .pool_data_out(pdata2), .pool_row_addr(prow2), .pool_col_addr(pcol2),
        .pool_valid(pvalid2), .pool_ready(pool_ready2),
        .busy(busy2), .done(done2)
    );

    // Layer-4 result memory: 1-cycle read for u_dut, 2-cycle read for u_dut2.
    logic [WW-1:0] mem [0:MW*MW-1];

    function automatic logic [WW-1:0] mem_rd(input logic [15:0] r, input logic [15:0] c);
        if (r < 16'(MW) && c < 16'(MW)) return mem[int'(r) * MW + int'(c)];
        return '0;
    endfunction

    always @(posedge clk) begin
        if (rsig1) rdata1 <= mem_rd(rrow1, rcol1);
        if (rsig2) rdata2a <= mem_rd(rrow2, rcol2);
        rdata2 <= rdata2a;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: per-lane signed max of each 2x2 window.
    function automatic int lane_of(input logic [WW-1:0] w, input int l);
        logic signed [15:0] s;
        s = w[l*16 +: 16];
        return int'(s);
    endfunction

    function automatic logic [WW-1:0] win_max(input int i, input int j);
        logic [WW-1:0] res;
        int base, m, v;
        base = 2 * i * MW + 2 * j;
        for (int l = 0; l < 8; l++) begin
            m = lane_of(mem[base], l);
            v = lane_of(mem[base + 1], l);      if (v > m) m = v;
            v = lane_of(mem[base + MW], l);     if (v > m) m = v;
            v = lane_of(mem[base + MW + 1], l); if (v > m) m = v;
`ifdef LAYER5_POOL_RELU_EN
            if (m < 0) m = 0;
`endif
            res[l*16 +: 16] = 16'(m);
        end
        return res;
    endfunction

    typedef struct {
        logic [WW-1:0] d;
        int            r;
        int            c;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp2_q[$];

    function automatic void push_pass(input bit second);
        exp_t e;
        for (int i = 0; i < MW / 2; i++) begin
            for (int j = 0; j < MW / 2; j++) begin
                e.d = win_max(i, j);
                e.r = i;
                e.c = j;
                if (second) exp2_q.push_back(e);
                else exp_q.push_back(e);
            end
        end
    endfunction

    // Monitor state for u_dut.
    int            hs_cnt = 0, done_cnt = 0, last_hs_cyc = 0, done_cyc = 0;
    int            hs2_cnt = 0, last_hs2_cyc = 0;
    logic [WW-1:0] out00, out55;
    bit            hold_pend = 1'b0;
    logic [WW-1:0] hold_d;
    logic [15:0]   hold_r, hold_c;
    exp_t          e1, e2;

    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (rsig1) chk("read_addr_range", WW'(rrow1 < 16'(MW) && rcol1 < 16'(MW)), WW'(1));
            if (hold_pend) begin
                chk("stall_valid", WW'(pvalid1), WW'(1));
                chk("stall_data", pdata1, hold_d);
                chk("stall_addr", WW'({prow1, pcol1}), WW'({hold_r, hold_c}));
                chk("stall_no_read", WW'(rsig1), WW'(0));
            end
            hold_pend = pvalid1 && !pool_ready;
            hold_d = pdata1;
            hold_r = prow1;
            hold_c = pcol1;
            if (pvalid1 && pool_ready) begin
                hs_cnt++;
                last_hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", WW'(1), WW'(0));
                end else begin
                    e1 = exp_q.pop_front();
                    chk("pool_data", pdata1, e1.d);
                    chk("pool_addr", WW'({prow1, pcol1}), WW'({16'(e1.r), 16'(e1.c)}));
                    if (e1.r == 0 && e1.c == 0) out00 = pdata1;
                    if (e1.r == 5 && e1.c == 5) out55 = pdata1;
                end
            end
            if (done1) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_low_at_done", WW'(busy1), WW'(0));
            end
        end
    end

    // Monitor for the READ_LATENCY=2 instance.
    always @(negedge clk) begin
        if (!rst && pvalid2 && pool_ready2) begin
            hs2_cnt++;
            last_hs2_cyc = cyc;
            if (exp2_q.size() == 0) begin
                chk("rl2_unexpected_output", WW'(1), WW'(0));
            end else begin
                e2 = exp2_q.pop_front();
                chk("rl2_pool_data", pdata2, e2.d);
                chk("rl2_pool_addr", WW'({prow2, pcol2}), WW'({16'(e2.r), 16'(e2.c)}));
            end
        end
    end

    // pool_ready driver: 0 = always ready, 1 = random, 2 = stall window (2,3).
    int ready_mode = 0;
    int stall_cnt = 0;
    initial begin
        pool_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: pool_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (pvalid1 && prow1 == 16'd2 && pcol1 == 16'd3 && stall_cnt < 10) begin
                        pool_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        pool_ready = 1'b1;
                    end
                end
                default: pool_ready = 1'b1;
            endcase
        end
    end

    task automatic wait_done(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, WW'(done_cnt >= target), WW'(1));
    endtask

    task automatic fill_random();
        for (int a = 0; a < MW * MW; a++) mem[a] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    int start_cyc, dbase;
    logic [15:0] exp_l0;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        for (int a = 0; a < MW * MW; a++) mem[a] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_read_sig", WW'(rsig1), WW'(0));
        chk("rst_read_addr", WW'({rrow1, rcol1}), WW'(0));
        chk("rst_pool_valid", WW'(pvalid1), WW'(0));
        chk("rst_pool_data", pdata1, WW'(0));
        chk("rst_pool_addr", WW'({prow1, pcol1}), WW'(0));
        chk("rst_busy_done", WW'({busy1, done1}), WW'(0));
        chk("rst_rl2_outputs", WW'({pvalid2, busy2, rsig2}), WW'(0));
        rst = 1'b0;

        // Ramp map on both latencies.
        for (int a = 0; a < MW * MW; a++) mem[a] = {8{16'(a)}};
        push_pass(1'b0);
        push_pass(1'b1);
        hs_cnt = 0;
        hs2_cnt = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        start2 = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        start2 = 1'b0;
        chk("busy_after_start", WW'(busy1), WW'(1));
        wait_done(1, 400, "ramp_done_timeout");
        begin
            int n;
            n = 0;
            while (hs2_cnt < 36 && n < 400) begin
                @(posedge clk);
                n++;
            end
        end
        repeat (5) @(posedge clk);
        #1;
        chk("ramp_done_once", WW'(done_cnt), WW'(1));
        chk("ramp_count", WW'(hs_cnt), WW'(36));
        chk("ramp_queue_empty", WW'(exp_q.size()), WW'(0));
        chk("ramp_last_hs_cycles", WW'(last_hs_cyc - start_cyc), WW'(216));
        chk("ramp_done_cycles", WW'(done_cyc - start_cyc), WW'(217));
        chk("ramp_out00", out00, {8{16'd13}});
        chk("ramp_out55", out55, {8{16'd143}});
        chk("rl2_count", WW'(hs2_cnt), WW'(36));
        chk("rl2_queue_empty", WW'(exp2_q.size()), WW'(0));
        chk("rl2_last_hs_cycles", WW'(last_hs2_cyc - start_cyc), WW'(252));

        // Random map, corner window (0,0), stall at (2,3), stray start mid-pass.
        fill_random();
        mem[0][15:0] = 16'hFFFB;   mem[0][127:112] = 16'h7FFF;
        mem[1][15:0] = 16'hFFFD;   mem[1][127:112] = 16'h8000;
        mem[12][15:0] = 16'hFFF9;  mem[12][127:112] = 16'h0001;
        mem[13][15:0] = 16'hFFF7;  mem[13][127:112] = 16'hFFFF;
        push_pass(1'b0);
        hs_cnt = 0;
        stall_cnt = 0;
        ready_mode = 2;
        dbase = done_cnt;
        @(posedge clk);
        #1;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(dbase + 1, 500, "stall_done_timeout");
        repeat (3) @(posedge clk);
        #1;
`ifdef LAYER5_POOL_RELU_EN
        exp_l0 = 16'h0000;
`else
        exp_l0 = 16'hFFFD;
`endif
        chk("stall_done_once", WW'(done_cnt - dbase), WW'(1));
        chk("stall_count", WW'(hs_cnt), WW'(36));
        chk("stall_queue_empty", WW'(exp_q.size()), WW'(0));
        chk("stall_cycles", WW'(stall_cnt), WW'(10));
        chk("stall_last_hs_cycles", WW'(last_hs_cyc - start_cyc), WW'(226));
        chk("stall_done_cycles", WW'(done_cyc - start_cyc), WW'(227));
        chk("corner_lane0", WW'(out00[15:0]), WW'(exp_l0));
        chk("corner_lane7", WW'(out00[127:112]), WW'(16'h7FFF));

        // Random throttling, reset during window (1,1), then a clean pass.
        fill_random();
        push_pass(1'b0);
        ready_mode = 1;
        dbase = done_cnt;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        begin
            int n;
            n = 0;
            while (!(rsig1 && rrow1 == 16'd2 && rcol1 == 16'd2) && n < 1000) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("reach_win11_timeout", WW'(n < 1000), WW'(1));
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_read", WW'({rsig1, rrow1, rcol1}), WW'(0));
        chk("midrst_pool", WW'({pvalid1, prow1, pcol1}), WW'(0));
        chk("midrst_pool_data", pdata1, WW'(0));
        chk("midrst_busy_done", WW'({busy1, done1}), WW'(0));
        rst = 1'b0;
        exp_q.delete();
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_no_done", WW'(done_cnt - dbase), WW'(0));
        push_pass(1'b0);
        hs_cnt = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(dbase + 1, 1500, "restart_done_timeout");
        repeat (3) @(posedge clk);
        #1;
        chk("restart_done_once", WW'(done_cnt - dbase), WW'(1));
        chk("restart_count", WW'(hs_cnt), WW'(36));
        chk("restart_queue_empty", WW'(exp_q.size()), WW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
